// File: rtl/rf_pkg.sv
// Shared definitions for the windowed integer register file.
//   NGLOBALS / REGS_PER_WIN : physical layout constants
//   clr_state_t             : clear-all sequencer state encoding
//   phys_idx()              : logical register + window -> physical entry
package rf_pkg;

    localparam int unsigned NGLOBALS     = 8;
    localparam int unsigned REGS_PER_WIN = 16;

    typedef enum logic {
        CLR_IDLE   = 1'b0,
        CLR_ACTIVE = 1'b1
    } clr_state_t;

    // Globals map straight through. Locals/ins live in the current window.
    // Outs alias the ins of the previous window (cwp-1 mod nwindows).
    function automatic logic [9:0] phys_idx(
        input logic [4:0]  addr,
        input logic [4:0]  cwp,
        input int unsigned nwindows
    );
        logic [9:0] win_s;
        logic [9:0] res_s;
        if (addr < 5'd8) begin
            win_s = 10'd0;
            res_s = {5'd0, addr};
        end else if (addr < 5'd16) begin
            win_s = (cwp == 5'd0) ? 10'(nwindows - 1) : ({5'd0, cwp} - 10'd1);
            // base(win) + 8 + (addr - 8) == 8 + 16*win + addr
            res_s = 10'd8 + (win_s << 4) + {5'd0, addr};
        end else begin
            win_s = {5'd0, cwp};
            // base(cwp) + (addr - 16)
            res_s = 10'd8 + (win_s << 4) + {5'd0, addr} - 10'd16;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/rf_addr_map.sv
// Combinational logical-to-physical register address translation.
//   addr : logical register r0..r31
//   cwp  : current window pointer
//   pidx : physical array entry
module rf_addr_map
    import rf_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = 3,
    parameter int PIDX_W   = 8
) (
    input  logic [4:0]        addr,
    input  logic [CWP_W-1:0]  cwp,
    output logic [PIDX_W-1:0] pidx
);

    logic [9:0] full_idx_s;

    assign full_idx_s = phys_idx(addr, 5'(cwp), NWINDOWS);
    assign pidx       = full_idx_s[PIDX_W-1:0];

endmodule

// File: rtl/register_file_windowed.sv
// Windowed integer register file: NWINDOWS overlapping windows + 8 globals.
// Ports:
//   Clk, Clr           : clock, synchronous active-high reset
//   PA_in/PB_in        : read addresses, PA_out/PB_out combinational data
//   PC_in, in, we      : synchronous write port
//   save, restore      : window commands (WIM-checked), win_ovf/win_unf traps
//   cwp_wr, cwp_in     : direct CWP load
//   wim                : window invalid mask
//   clr_all, busy      : clear-all sequencer start / active flag
//   cwp, cmd_err       : current window pointer, save+restore conflict pulse
// Build option: RF_BYPASS_EN forwards a same-cycle write to the read ports.
module register_file_windowed
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 8,
    localparam int CWP_W   = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1,
    localparam int P       = NGLOBALS + REGS_PER_WIN * NWINDOWS,
    localparam int PIDX_W  = $clog2(P)
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [4:0]          PA_in,
    input  logic [4:0]          PB_in,
    output logic [DATA_W-1:0]   PA_out,
    output logic [DATA_W-1:0]   PB_out,
    input  logic [4:0]          PC_in,
    input  logic [DATA_W-1:0]   in,
    input  logic                we,
    input  logic                save,
    input  logic                restore,
    input  logic                cwp_wr,
    input  logic [CWP_W-1:0]    cwp_in,
    input  logic [NWINDOWS-1:0] wim,
    input  logic                clr_all,
    output logic [CWP_W-1:0]    cwp,
    output logic                win_ovf,
    output logic                win_unf,
    output logic                cmd_err,
    output logic                busy
);

    logic [DATA_W-1:0] regs_r [P];

    logic [CWP_W-1:0]  cwp_r;
    logic              win_ovf_r;
    logic              win_unf_r;
    logic              cmd_err_r;
    clr_state_t        state_r;
    clr_state_t        state_nx_s;
    logic [PIDX_W-1:0] idx_r;
    logic [PIDX_W-1:0] idx_nx_s;

    logic [PIDX_W-1:0] pa_idx_s;
    logic [PIDX_W-1:0] pb_idx_s;
    logic [PIDX_W-1:0] pc_idx_s;
    logic              last_clear_s;
    logic              wr_ok_s;
    logic              cmd_ok_s;
    logic [CWP_W-1:0]  cwp_dec_s;
    logic [CWP_W-1:0]  cwp_inc_s;

    rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PIDX_W(PIDX_W)) u_map_a (
        .addr (PA_in),
        .cwp  (cwp_r),
        .pidx (pa_idx_s)
    );

    rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PIDX_W(PIDX_W)) u_map_b (
        .addr (PB_in),
        .cwp  (cwp_r),
        .pidx (pb_idx_s)
    );

    rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PIDX_W(PIDX_W)) u_map_c (
        .addr (PC_in),
        .cwp  (cwp_r),
        .pidx (pc_idx_s)
    );

    assign last_clear_s = (state_r == CLR_ACTIVE) && (idx_r == PIDX_W'(P - 1));

    // The edge on which busy falls still accepts a user write; it lands after
    // the clear write so it wins if both hit the same entry.
    assign wr_ok_s  = !Clr && we && (PC_in != 5'd0) &&
                      ((state_r == CLR_IDLE) || last_clear_s);

    // Window commands are blocked by a running sequence or by its start.
    assign cmd_ok_s = (state_r == CLR_IDLE) && !clr_all;

    assign cwp_dec_s = (cwp_r == {CWP_W{1'b0}}) ? CWP_W'(NWINDOWS - 1) : (cwp_r - 1'b1);
    assign cwp_inc_s = (cwp_r == CWP_W'(NWINDOWS - 1)) ? {CWP_W{1'b0}} : (cwp_r + 1'b1);

    // Clear sequencer next-state and index computation.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            CLR_IDLE: begin
                if (clr_all) begin
                    state_nx_s = CLR_ACTIVE;
                    idx_nx_s   = {PIDX_W{1'b0}};
                end else begin
                    state_nx_s = CLR_IDLE;
                end
            end
            CLR_ACTIVE: begin
                if (last_clear_s) begin
                    state_nx_s = CLR_IDLE;
                    idx_nx_s   = {PIDX_W{1'b0}};
                end else begin
                    idx_nx_s   = idx_r + 1'b1;
                end
            end
            default: begin
                state_nx_s = CLR_IDLE;
                idx_nx_s   = {PIDX_W{1'b0}};
            end
        endcase
    end

    // Clear sequencer state register.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_r <= CLR_IDLE;
            idx_r   <= {PIDX_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Window pointer and single-cycle trap/error pulses.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            cwp_r     <= {CWP_W{1'b0}};
            win_ovf_r <= 1'b0;
            win_unf_r <= 1'b0;
            cmd_err_r <= 1'b0;
        end else begin
            win_ovf_r <= 1'b0;
            win_unf_r <= 1'b0;
            cmd_err_r <= 1'b0;
            if (!cmd_ok_s) begin
                cwp_r <= cwp_r;
            end else if (cwp_wr) begin
                cwp_r <= cwp_in;
            end else if (save && restore) begin
                cmd_err_r <= 1'b1;
            end else if (save) begin
                if (wim[cwp_dec_s]) begin
                    win_ovf_r <= 1'b1;
                end else begin
                    cwp_r <= cwp_dec_s;
                end
            end else if (restore) begin
                if (wim[cwp_inc_s]) begin
                    win_unf_r <= 1'b1;
                end else begin
                    cwp_r <= cwp_inc_s;
                end
            end else begin
                cwp_r <= cwp_r;
            end
        end
    end

    // Register array: sequencer clear write, then user write (array not reset).
    always_ff @(posedge Clk) begin
        if (!Clr && (state_r == CLR_ACTIVE)) begin
            regs_r[idx_r] <= {DATA_W{1'b0}};
        end
        if (wr_ok_s) begin
            regs_r[pc_idx_s] <= in;
        end
    end

    // Read ports: r0 is hard-wired zero.
    always_comb begin
        PA_out = {DATA_W{1'b0}};
        PB_out = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
        if (PA_in == 5'd0) begin
            PA_out = {DATA_W{1'b0}};
        end else if (wr_ok_s && (pa_idx_s == pc_idx_s)) begin
            PA_out = in;
        end else begin
            PA_out = regs_r[pa_idx_s];
        end
        if (PB_in == 5'd0) begin
            PB_out = {DATA_W{1'b0}};
        end else if (wr_ok_s && (pb_idx_s == pc_idx_s)) begin
            PB_out = in;
        end else begin
            PB_out = regs_r[pb_idx_s];
        end
`else
        if (PA_in == 5'd0) begin
            PA_out = {DATA_W{1'b0}};
        end else begin
            PA_out = regs_r[pa_idx_s];
        end
        if (PB_in == 5'd0) begin
            PB_out = {DATA_W{1'b0}};
        end else begin
            PB_out = regs_r[pb_idx_s];
        end
`endif
    end

    assign cwp     = cwp_r;
    assign win_ovf = win_ovf_r;
    assign win_unf = win_unf_r;
    assign cmd_err = cmd_err_r;
    assign busy    = (state_r == CLR_ACTIVE);

endmodule

// File: doc/register_file_windowed.md
# register_file_windowed

Parametrised SPARC V8 windowed integer register file: NWINDOWS overlapping windows plus 8 globals, two combinational read ports (A, B) and one synchronous write port (C). It is the next-generation register file of the integer datapath. Unlike the fixed 4-window file, it owns the current window pointer (CWP), executes SAVE/RESTORE with WIM-based overflow/underflow detection, and has a multi-cycle clear-all sequencer.

## Interface
- DATA_W, 32: register width.
- NWINDOWS, 8: window count, 2..32; CWP width CWP_W = clog2(NWINDOWS), minimum 1.
- Clk  in  1  clock; all state changes on rising edge.
- Clr  in  1  reset, synchronous, active-high.
- PA_in, PB_in  in  5  read addresses r0..r31.
- PA_out, PB_out  out  DATA_W  read data, combinational.
- PC_in  in  5  write address.
- in  in  DATA_W  write data.
- we  in  1  write enable.
- save, restore  in  1  window commands, one-cycle pulses.
- cwp_wr  in  1  direct CWP load (WRPSR).
- cwp_in  in  CWP_W  value for cwp_wr.
- wim  in  NWINDOWS  window invalid mask.
- clr_all  in  1  start clear-all sequence.
- cwp  out  CWP_W  current window pointer, registered.
- win_ovf, win_unf  out  1  overflow/underflow trap pulses, registered.
- cmd_err  out  1  save and restore both asserted, registered pulse.
- busy  out  1  clear sequencer active.

## Operation
- Physical array: P = 8 + 16*NWINDOWS entries. Globals occupy 0..7. Window w occupies base(w) = 8+16w: locals r16..r23 map to base+0..7, ins r24..r31 map to base+8..15.
- Outs r8..r15 of window w alias the ins of window (w-1) mod NWINDOWS: base((w-1) mod NW)+8+(r-8).
- r0 always reads 0. Writes to r0 are discarded.
- Reads and writes map through the current cwp value.
- save: n = (cwp-1) mod NW. If wim[n] = 1, pulse win_ovf and keep cwp. Otherwise cwp <= n.
- restore: n = (cwp+1) mod NW. If wim[n] = 1, pulse win_unf and keep cwp. Otherwise cwp <= n.
- save and restore in the same cycle: neither is performed; cmd_err pulses.
- Priority, highest first: Clr, clear sequencer (start or busy), cwp_wr, save/restore.
- A write in the same cycle as save/restore/cwp_wr uses the old cwp.
- Clear sequencer FSM has two states:
  - IDLE: clr_all=1 moves to CLEAR with idx=0.
  - CLEAR: writes 0 to physical entry idx each cycle, then idx++. After idx = P-1 it returns to IDLE.
  - busy=1 exactly while in CLEAR.
  - While busy, we, save, restore and cwp_wr are ignored; no trap or cmd_err pulses; reads return current array contents.
  - clr_all while busy is ignored.
- Reset sets cwp=0, win_ovf=win_unf=cmd_err=0, busy=0, FSM to IDLE. Array contents are not reset.
- Reset during CLEAR aborts the sequence; already-cleared entries stay cleared.

## Timing
- Write: the value is visible on a read port from the cycle after the rising edge.
- Trap/err pulses: high for exactly one cycle, the cycle after the command edge.
- cwp updates on the command edge; reads in the next cycle use the new window.
- Clear-all takes P cycles. busy rises the cycle after the clr_all edge and falls after P cycles. A write accepted at that falling edge is honoured.

## Configuration
- RF_BYPASS_EN defined: a read whose address maps to the same physical entry as an enabled, accepted write in the same cycle returns `in` combinationally (r0 excluded).
- RF_BYPASS_EN undefined: the read returns the old array value until the next cycle.

## Structure
- Shared package rf_pkg holds:
  - constants NGLOBALS=8 and REGS_PER_WIN=16;
  - typedef of the clear FSM state enum;
  - function phys_idx(logical addr, cwp, nwindows).
- Sub-module rf_addr_map performs the combinational logical-to-physical translation. It is instantiated three times (A, B, C).

## Test plan
- NWINDOWS=4, cwp=0: write r8=0x11, then save → cwp=3; read r24 → 0x11 (out/in overlap).
- wim=4'b1000, cwp=0: save → win_ovf pulses one cycle, cwp stays 0. With wim=0, restore from cwp=3 → cwp=0 (wrap).
- Write r3=0x55 in cwp=0, switch to cwp=2: r3 reads 0x55. Write r0=7: r0 reads 0.
- save and restore together → cmd_err pulses, cwp unchanged. cwp_wr with save → cwp=cwp_in.
- Fill all entries, pulse clr_all: busy high 72 cycles (NW=4), a write during busy is dropped, all reads 0 afterwards. Assert Clr at cycle 10 of the sequence → busy=0, cwp=0, entries at index ≥10 keep their values.
- Write r17=0x99 while reading PA_in=17 in the same cycle: PA_out=0x99 with RF_BYPASS_EN, old value without it.
